// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode digit-entry controller.
// Holds the FSM state encoding, the largest legal BCD digit and the default idle timeout.
package barcode_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY    = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   localparam int BCD_MAX = 9;

   // 5 s of inactivity at 50 MHz
   localparam int DEFAULT_TIMEOUT = 250000000;

endpackage

// File: rtl/barcode_entry_ctrl_if.sv
// Strobe and result bundle between the digit source and the entry controller.
// master: ENABLE/Digit_in/BACKSPACE/CLEAR/ACK out, results in; slave: the reverse.
interface barcode_entry_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 4,
   parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
);

   logic                          ENABLE;
   logic [DIGIT_W-1:0]            Digit_in;
   logic                          BACKSPACE;
   logic                          CLEAR;
   logic                          ACK;
   logic [NUM_DIGITS*DIGIT_W-1:0] Barcode;
   logic [CNT_W-1:0]              NumDigitsEntered;
   logic                          Completed;
   logic                          Busy;
   logic                          Invalid_pulse;
   logic                          Timeout_pulse;

   modport master (
      output ENABLE, Digit_in, BACKSPACE, CLEAR, ACK,
      input  Barcode, NumDigitsEntered, Completed, Busy,
      input  Invalid_pulse, Timeout_pulse
   );

   modport slave (
      input  ENABLE, Digit_in, BACKSPACE, CLEAR, ACK,
      output Barcode, NumDigitsEntered, Completed, Busy,
      output Invalid_pulse, Timeout_pulse
   );

endinterface

// File: rtl/entry_timeout_timer.sv
// Inactivity timer: counts while run is high, restarts on any strobe.
// Ports: CLK, RESET_N (sync, active-low), run, restart in; expired out (combinational pulse).
module entry_timeout_timer
   import barcode_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic run,
   input  logic restart,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int W = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

         logic [W-1:0] cnt;

         always_ff @(posedge CLK) begin
            if (!RESET_N || !run || restart || cnt == LAST)
               cnt <= '0;
            else
               cnt <= cnt + 1'b1;
         end

         // A strobe on the expiry cycle wins over the timeout
         assign expired = run && !restart && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/barcode_entry_ctrl.sv
// Assembles strobed BCD digits into a NUM_DIGITS code with backspace/clear/timeout.
// Ports: CLK, RESET_N (sync, active-low), bus (slave: strobes in, code/status out).
module barcode_entry_ctrl
   import barcode_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DIGIT_W        = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int CNT_W          = $clog2(NUM_DIGITS + 1)
) (
   input logic                 CLK,
   input logic                 RESET_N,
   barcode_entry_ctrl_if.slave bus
);

   localparam int CW = NUM_DIGITS * DIGIT_W;
   localparam logic [CNT_W-1:0]   FULL  = CNT_W'(NUM_DIGITS);
   localparam logic [CNT_W-1:0]   LASTC = CNT_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);
   localparam logic [DIGIT_W-1:0] DMAX  = DIGIT_W'(BCD_MAX);

   state_t           state, state_n;
   logic [CW-1:0]    code, code_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             inv_n, to_n;
   logic             cmp_q, busy_q, inv_q, to_q;
   logic             expired, digit_ok;

   assign digit_ok = (bus.Digit_in <= DMAX);

   entry_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .run     (state == ENTRY),
      .restart (bus.ENABLE | bus.BACKSPACE | bus.CLEAR),
      .expired (expired)
   );

   always_comb begin
      state_n = state;
      code_n  = code;
      cnt_n   = cnt;
      inv_n   = 1'b0;
      to_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.CLEAR && !bus.BACKSPACE && bus.ENABLE) begin
               if (digit_ok) begin
                  code_n  = CW'(bus.Digit_in);
                  cnt_n   = ONE;
                  state_n = (NUM_DIGITS == 1) ? COMPLETE : ENTRY;
               end else begin
                  inv_n = 1'b1;
               end
            end
         end
         ENTRY: begin
            if (bus.CLEAR) begin
               code_n  = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (bus.BACKSPACE) begin
               for (int k = 0; k < NUM_DIGITS; k++)
                  if (k == int'(cnt) - 1)
                     code_n[k*DIGIT_W +: DIGIT_W] = '0;
               cnt_n = cnt - 1'b1;
               if (cnt == ONE)
                  state_n = IDLE;
            end else if (bus.ENABLE) begin
               if (digit_ok) begin
                  for (int k = 0; k < NUM_DIGITS; k++)
                     if (k == int'(cnt))
                        code_n[k*DIGIT_W +: DIGIT_W] = bus.Digit_in;
                  cnt_n = cnt + 1'b1;
                  if (cnt_n == FULL)
                     state_n = COMPLETE;
               end else begin
                  inv_n = 1'b1;
               end
            end else if (expired) begin
               code_n  = '0;
               cnt_n   = '0;
               state_n = IDLE;
               to_n    = 1'b1;
            end
         end
         COMPLETE: begin
            // ACK sits just below CLEAR so an accepted code is never
            // reopened or flagged invalid by a coincident strobe
            if (bus.CLEAR || bus.ACK) begin
               code_n  = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (bus.BACKSPACE) begin
               code_n[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W] = '0;
               cnt_n   = LASTC;
               state_n = (NUM_DIGITS == 1) ? IDLE : ENTRY;
            end else if (bus.ENABLE) begin
               inv_n = 1'b1;
            end
         end
         default: begin
            code_n  = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state  <= IDLE;
         code   <= '0;
         cnt    <= '0;
         cmp_q  <= 1'b0;
         busy_q <= 1'b0;
         inv_q  <= 1'b0;
         to_q   <= 1'b0;
      end else begin
         state  <= state_n;
         code   <= code_n;
         cnt    <= cnt_n;
         cmp_q  <= (state_n == COMPLETE);
         busy_q <= (state_n != IDLE);
         inv_q  <= inv_n;
         to_q   <= to_n;
      end
   end

   assign bus.Barcode          = code;
   assign bus.NumDigitsEntered = cnt;
   assign bus.Completed        = cmp_q;
   assign bus.Busy             = busy_q;
   assign bus.Invalid_pulse    = inv_q;
   assign bus.Timeout_pulse    = to_q;

endmodule

// File: tb/tb_barcode_entry_ctrl.sv
// Randomised and directed bench for barcode_entry_ctrl against a queue-based model.
// Ports: none; drives the bus interface master side and checks every cycle.
module tb_barcode_entry_ctrl;

   localparam int ND = 4;
   localparam int TO = 100;

   logic CLK = 1'b0;
   logic RESET_N;
   int   total = 0;
   int   bad = 0;

   always #5 CLK = ~CLK;

   barcode_entry_ctrl_if #(.NUM_DIGITS(ND), .DIGIT_W(4)) bus ();

   barcode_entry_ctrl #(
      .NUM_DIGITS     (ND),
      .DIGIT_W        (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   // Model: the entered digits as a queue, plus idle-cycle count
   int q[$];
   int quiet = 0;
   bit m_inv = 0;
   bit m_to = 0;

   always @(posedge CLK) begin
      bit en, bs, cl, ak, strobe;
      int d, n;
      en = bus.ENABLE;
      bs = bus.BACKSPACE;
      cl = bus.CLEAR;
      ak = bus.ACK;
      d  = int'(bus.Digit_in);
      n  = q.size();
      m_inv = 0;
      m_to  = 0;
      if (!RESET_N) begin
         q.delete();
         quiet = 0;
      end else begin
         strobe = en | bs | cl;
         if (cl) q.delete();
         else if (ak && n == ND) q.delete();
         else if (bs) begin
            if (n > 0) void'(q.pop_back());
         end else if (en) begin
            if (n == ND || d > 9) m_inv = 1;
            else q.push_back(d);
         end else if (n > 0 && n < ND && quiet == TO - 1) begin
            q.delete();
            m_to = 1;
         end
         if (!strobe && !m_to && n > 0 && n < ND) quiet++;
         else quiet = 0;
      end
   end

   function automatic logic [15:0] model_code();
      logic [15:0] c;
      c = '0;
      for (int k = 0; k < q.size(); k++)
         c = c | (16'(q[k]) << (4 * k));
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      chk("code", 32'(bus.Barcode), 32'(model_code()));
      chk("count", 32'(bus.NumDigitsEntered), 32'(q.size()));
      chk("completed", 32'(bus.Completed), 32'(q.size() == ND));
      chk("busy", 32'(bus.Busy), 32'(q.size() != 0));
      chk("invalid", 32'(bus.Invalid_pulse), 32'(m_inv));
      chk("timeout", 32'(bus.Timeout_pulse), 32'(m_to));
   end

   task automatic step(input bit en, input int d, input bit bs,
                       input bit cl, input bit ak);
      bus.ENABLE    = en;
      bus.Digit_in  = 4'(d);
      bus.BACKSPACE = bs;
      bus.CLEAR     = cl;
      bus.ACK       = ak;
      @(negedge CLK);
      bus.ENABLE    = 1'b0;
      bus.BACKSPACE = 1'b0;
      bus.CLEAR     = 1'b0;
      bus.ACK       = 1'b0;
   endtask

   task automatic dig(input int d);
      step(1, d, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int seen;
      bit en, bs, cl, ak;
      RESET_N       = 1'b0;
      bus.ENABLE    = 1'b0;
      bus.Digit_in  = '0;
      bus.BACKSPACE = 1'b0;
      bus.CLEAR     = 1'b0;
      bus.ACK       = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_code", 32'(bus.Barcode), 0);
      chk("rst_busy", 32'(bus.Busy), 0);
      RESET_N = 1'b1;

      // 1: full code then ACK
      dig(1); dig(2); dig(3);
      chk("t1_notdone", 32'(bus.Completed), 0);
      dig(4);
      chk("t1_code", 32'(bus.Barcode), 32'h4321);
      chk("t1_cnt", 32'(bus.NumDigitsEntered), 4);
      chk("t1_done", 32'(bus.Completed), 1);
      step(0, 0, 0, 0, 1);
      chk("t1_ack_code", 32'(bus.Barcode), 0);
      chk("t1_ack_busy", 32'(bus.Busy), 0);

      // 2: backspace
      dig(7); dig(8); dig(9);
      step(0, 0, 1, 0, 0);
      chk("t2_code", 32'(bus.Barcode), 32'h0087);
      chk("t2_cnt", 32'(bus.NumDigitsEntered), 2);
      chk("t2_busy", 32'(bus.Busy), 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("t2_cnt0", 32'(bus.NumDigitsEntered), 0);
      chk("t2_idle", 32'(bus.Busy), 0);

      // 3: invalid digit
      dig(5);
      dig(10);
      chk("t3_inv", 32'(bus.Invalid_pulse), 1);
      chk("t3_cnt", 32'(bus.NumDigitsEntered), 1);
      chk("t3_code", 32'(bus.Barcode), 32'h0005);
      idle(1);
      chk("t3_inv_off", 32'(bus.Invalid_pulse), 0);
      step(0, 0, 0, 1, 0);

      // 4: timeout, then strobe on the expiry cycle
      dig(3);
      seen = 0;
      for (int i = 0; i < TO; i++) begin
         idle(1);
         seen += int'(bus.Timeout_pulse);
      end
      chk("t4_pulse", 32'(bus.Timeout_pulse), 1);
      chk("t4_code", 32'(bus.Barcode), 0);
      chk("t4_busy", 32'(bus.Busy), 0);
      idle(3);
      chk("t4_once", 32'(seen), 1);
      dig(3);
      seen = 0;
      for (int i = 0; i < TO - 1; i++) begin
         idle(1);
         seen += int'(bus.Timeout_pulse);
      end
      dig(2);
      seen += int'(bus.Timeout_pulse);
      chk("t4_none", 32'(seen), 0);
      chk("t4_code2", 32'(bus.Barcode), 32'h0023);
      step(0, 0, 0, 1, 0);

      // 5: CLEAR beats ENABLE; ENABLE in COMPLETE is invalid
      dig(1); dig(2);
      step(1, 6, 0, 1, 0);
      chk("t5_code", 32'(bus.Barcode), 0);
      chk("t5_noinv", 32'(bus.Invalid_pulse), 0);
      dig(4); dig(3); dig(2); dig(1);
      dig(1);
      chk("t5_inv", 32'(bus.Invalid_pulse), 1);
      chk("t5_held", 32'(bus.Barcode), 32'h1234);
      step(0, 0, 0, 0, 1);

      // 6: reset mid-entry, completed code held without ACK
      dig(1); dig(2); dig(3);
      chk("t6_cnt3", 32'(bus.NumDigitsEntered), 3);
      RESET_N = 1'b0;
      idle(1);
      RESET_N = 1'b1;
      chk("t6_code", 32'(bus.Barcode), 0);
      chk("t6_cnt", 32'(bus.NumDigitsEntered), 0);
      chk("t6_busy", 32'(bus.Busy), 0);
      dig(5); dig(6); dig(7); dig(8);
      seen = 0;
      for (int i = 0; i < 1000; i++) begin
         idle(1);
         seen += int'(bus.Timeout_pulse);
      end
      chk("t6_hold", 32'(bus.Completed), 1);
      chk("t6_hold_code", 32'(bus.Barcode), 32'h8765);
      chk("t6_noto", 32'(seen), 0);
      step(0, 0, 0, 0, 1);

      // Random: alternating dense and sparse phases
      for (int i = 0; i < 4000; i++) begin
         en = $urandom_range(0, 99) < 35;
         bs = $urandom_range(0, 9) == 0;
         cl = $urandom_range(0, 19) == 0;
         ak = !en && !bs && !cl && ($urandom_range(0, 3) == 0);
         if (((i / 500) % 2 == 1) && $urandom_range(0, 119) != 0) begin
            en = 0; bs = 0; cl = 0; ak = 0;
         end
         RESET_N = ($urandom_range(0, 599) != 0);
         step(en, int'($urandom_range(0, 11)), bs, cl, ak);
      end
      RESET_N = 1'b1;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
